// File: rtl/sw_halfduplex_responder.sv
// Responder end of a single-wire half-duplex link: receives one framed byte, turns the line
// around and optionally replies. Define SW_RESPONDER_PARITY_EN to add an even-parity bit.
module sw_halfduplex_responder #(
  parameter int BIT_CYCLES  = 16,
  parameter int TURN_CYCLES = 4,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  output logic              data_out,
  output logic              data_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ack,
  output logic              busy
);

`ifdef SW_RESPONDER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int NB    = DATA_W + PAR_W;
  localparam int CMAX  = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
  localparam int CNT_W = $clog2(CMAX) + 1;
  localparam int BIT_W = $clog2(NB + 1) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [BIT_W-1:0] NB_LAST   = BIT_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, RX_START, RX_DATA, RX_STOP, TURN, TX_START, TX_DATA, TX_STOP
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [BIT_W-1:0]  bit_idx, bit_idx_nx;
  logic              sync_p0, s_in, s_prev;
  logic [NB-1:0]     rx_sr, rx_sr_nx;
  logic [NB-1:0]     tx_sr, tx_sr_nx;
  logic [NB-1:0]     tx_load;
  logic [DATA_W-1:0] rx_data_nx;
  logic              rx_valid_nx, rx_err_nx, tx_ack_nx;
  logic              drive_en_nx, drive_out_nx;
  logic              par_ok;

`ifdef SW_RESPONDER_PARITY_EN
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Data and parity bits together must hold an even number of ones.
  assign par_ok  = ~^rx_sr;
  assign tx_load = {even_par(tx_data), tx_data};
`else
  assign par_ok  = 1'b1;
  assign tx_load = tx_data;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + 1'b1;
    bit_idx_nx   = bit_idx;
    rx_sr_nx     = rx_sr;
    tx_sr_nx     = tx_sr;
    rx_data_nx   = rx_data;
    rx_valid_nx  = 1'b0;
    rx_err_nx    = 1'b0;
    tx_ack_nx    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx     = '0;
        bit_idx_nx = '0;
        if (s_prev && !s_in) state_nx = RX_START;
      end
      RX_START: if (cnt == HALF_LAST) begin
        cnt_nx   = '0;
        state_nx = s_in ? IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == BIT_LAST) begin
        cnt_nx     = '0;
        rx_sr_nx   = {s_in, rx_sr[NB-1:1]};
        bit_idx_nx = bit_idx + 1'b1;
        if (bit_idx == NB_LAST) state_nx = RX_STOP;
      end
      RX_STOP: if (cnt == BIT_LAST) begin
        cnt_nx = '0;
        if (s_in && par_ok) begin
          rx_valid_nx = 1'b1;
          rx_data_nx  = rx_sr[DATA_W-1:0];
          state_nx    = TURN;
        end else begin
          rx_err_nx = 1'b1;
          state_nx  = IDLE;
        end
      end
      TURN: if (cnt == TURN_LAST) begin
        cnt_nx     = '0;
        bit_idx_nx = '0;
        if (tx_valid) begin
          tx_ack_nx = 1'b1;
          tx_sr_nx  = tx_load;
          state_nx  = TX_START;
        end else begin
          state_nx = IDLE;
        end
      end
      TX_START: if (cnt == BIT_LAST) begin
        cnt_nx   = '0;
        state_nx = TX_DATA;
      end
      TX_DATA: if (cnt == BIT_LAST) begin
        cnt_nx     = '0;
        tx_sr_nx   = tx_sr >> 1;
        bit_idx_nx = bit_idx + 1'b1;
        if (bit_idx == NB_LAST) state_nx = TX_STOP;
      end
      TX_STOP: if (cnt == BIT_LAST) begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Pad controls are decoded from the next state so they leave a flop glitch-free.
    drive_en_nx  = (state_nx == TX_START) || (state_nx == TX_DATA) || (state_nx == TX_STOP);
    drive_out_nx = 1'b1;
    if (state_nx == TX_START)     drive_out_nx = 1'b0;
    else if (state_nx == TX_DATA) drive_out_nx = tx_sr_nx[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sync_p0  <= 1'b1;
      s_in     <= 1'b1;
      s_prev   <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      tx_ack   <= 1'b0;
      data_en  <= 1'b0;
      data_out <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_idx_nx;
      sync_p0  <= data_in;
      s_in     <= sync_p0;
      s_prev   <= s_in;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      rx_err   <= rx_err_nx;
      tx_ack   <= tx_ack_nx;
      data_en  <= drive_en_nx;
      data_out <= drive_out_nx;
    end
  end

  // Shift registers carry payload only and need no reset.
  always_ff @(posedge clk) begin
    rx_sr <= rx_sr_nx;
    tx_sr <= tx_sr_nx;
  end

endmodule

// File: tb/tb_sw_halfduplex_responder.sv
// Scoreboard bench for sw_halfduplex_responder: stimulus pushes expected events/replies,
// negedge monitors pop and compare when the DUT pulses or releases the line.
module tb_sw_halfduplex_responder;
  localparam int BC   = 16;
  localparam int TURN = 4;
  localparam int DW   = 8;
`ifdef SW_RESPONDER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBF = DW + PB + 2;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_ERR   = 2'd1;
  localparam logic [1:0] K_ACK   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       reply;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          line_drv = 1'b1;
  logic          data_in, data_out, data_en;
  logic [DW-1:0] rx_data, tx_data;
  logic          rx_valid, rx_err, tx_valid, tx_ack, busy;

  ev_t        evq[$];
  logic [7:0] rq[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_valid = -100;
  int busy_at = -100;
  int en_cnt = 0;
  int en_total = 0;
  bit aborted = 1'b0;
  logic [15:0] rbits = '0;

  assign data_in = data_en ? data_out : line_drv;

  sw_halfduplex_responder #(.BIT_CYCLES(BC), .TURN_CYCLES(TURN), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .data_en(data_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic line_bit(input logic b);
    line_drv = b;
    repeat (BC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    line_bit(1'b0);
    for (int i = 0; i < DW; i++) line_bit(d[i]);
`ifdef SW_RESPONDER_PARITY_EN
    line_bit(^d);
`endif
    line_bit(stop_b);
  endtask

`ifdef SW_RESPONDER_PARITY_EN
  task automatic send_bad_par(input logic [7:0] d);
    line_bit(1'b0);
    for (int i = 0; i < DW; i++) line_bit(d[i]);
    line_bit(~^d);
    line_bit(1'b1);
  endtask
`endif

  task automatic push_ev(input logic [1:0] k, input logic [7:0] d, input logic r);
    ev_t e;
    e.kind = k; e.data = d; e.reply = r;
    evq.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data_en"}, data_en, 1'b0);
    check({tag, "_data_out"}, data_out, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pulses"}, {rx_valid, rx_err, tx_ack}, 3'b000);
  endtask

  // Pulse scoreboard and turnaround timing.
  always @(negedge clk) begin
    ev_t e;
    logic [1:0] k;
    if (rx_valid || rx_err || tx_ack) begin
      check("pulse_onehot", $countones({rx_valid, rx_err, tx_ack}), 1);
      if (evq.size() == 0) begin
        check("unexpected_pulse", {rx_valid, rx_err, tx_ack}, 3'b000);
      end else begin
        e = evq.pop_front();
        k = rx_valid ? K_VALID : (rx_err ? K_ERR : K_ACK);
        check("event_kind", k, e.kind);
        if (rx_valid) begin
          check("rx_data", rx_data, e.data);
          last_valid = cyc;
          if (!e.reply) busy_at = cyc + TURN;
        end
        if (tx_ack) check("ack_latency", cyc - last_valid, TURN);
      end
    end
    if (cyc == busy_at - 1) check("busy_in_turn", busy, 1'b1);
    if (cyc == busy_at) check("busy_released", busy, 1'b0);
  end

  // Reply decoder: samples mid-bit while the DUT owns the line.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (data_en) begin
      if (rst) aborted = 1'b1;
      if ((en_cnt % BC) == BC / 2 && (en_cnt / BC) < 16) rbits[en_cnt / BC] = data_out;
      en_cnt++;
      en_total++;
    end else if (en_cnt != 0) begin
      if (!aborted) begin
        if (rq.size() == 0) begin
          check("unexpected_reply", en_cnt, 0);
        end else begin
          exp = rq.pop_front();
          check("reply_len", en_cnt, NBF * BC);
          check("reply_start", rbits[0], 1'b0);
          check("reply_data", rbits[DW:1], exp);
`ifdef SW_RESPONDER_PARITY_EN
          check("reply_parity", rbits[DW+1], ^exp);
`endif
          check("reply_stop", rbits[NBF-1], 1'b1);
        end
      end
      en_cnt = 0;
      aborted = 1'b0;
    end
  end

  initial begin
    repeat (2000000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int waited;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rx_data", rx_data, 8'h00);
    repeat (10) @(posedge clk);
    #1;

    // Good receive, no reply offered.
    snap = en_total;
    push_ev(K_VALID, 8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("no_drive_A5", en_total, snap);

    // Receive then reply 0x96.
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    push_ev(K_VALID, 8'h3C, 1'b1);
    push_ev(K_ACK, 8'h00, 1'b1);
    rq.push_back(8'h96);
    send_frame(8'h3C, 1'b1);
    repeat (200) @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Framing error, line stuck low afterwards.
    push_ev(K_ERR, 8'h00, 1'b0);
    send_frame(8'h55, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("stuck_low_idle", busy, 1'b0);
    check("err_holds_rx_data", rx_data, 8'h3C);
    @(posedge clk);
    #1 line_drv = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Short glitch, then a valid frame.
    line_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1 line_drv = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("glitch_idle", busy, 1'b0);
    @(posedge clk);
    #1;
    push_ev(K_VALID, 8'h01, 1'b0);
    send_frame(8'h01, 1'b1);
    repeat (30) @(posedge clk);
    #1;

    // Reset in the middle of a reply.
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    push_ev(K_VALID, 8'h5A, 1'b1);
    push_ev(K_ACK, 8'h00, 1'b1);
    send_frame(8'h5A, 1'b1);
    waited = 0;
    while (!data_en && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("reply_started", data_en, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("mid_reply_en", data_en, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;

`ifdef SW_RESPONDER_PARITY_EN
    // Bad parity rejected, good parity accepted and answered with 0x03 (parity 0).
    push_ev(K_ERR, 8'h00, 1'b0);
    send_bad_par(8'h07);
    repeat (20) @(posedge clk);
    #1;
    tx_data  = 8'h03;
    tx_valid = 1'b1;
    push_ev(K_VALID, 8'h07, 1'b1);
    push_ev(K_ACK, 8'h00, 1'b1);
    rq.push_back(8'h03);
    send_frame(8'h07, 1'b1);
    repeat (220) @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`endif

    check("events_drained", evq.size(), 0);
    check("replies_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sw_halfduplex_responder.md
Name: sw_halfduplex_responder

Overview:
- Responder end of the single-wire, half-duplex bidirectional data line driven through the pad wrapper (data_out/data_en/data_in per end).
- Receives one framed byte from the initiator, turns the line around, and optionally replies with one framed byte.
- Drives the line only while its own reply is on the wire; otherwise the line is released.

Parameters:
- BIT_CYCLES, 16, clk cycles per bit; even, >=4.
- TURN_CYCLES, 4, idle clk cycles between rx_valid and the reply start bit; >=1.
- DATA_W, 8, payload bits per frame, LSB first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  1  line value from pad (asynchronous to clk).
- data_out  output  1  value to drive on line; 1 when not driving.
- data_en  output  1  pad output enable; 1 only during reply frame.
- rx_data  output  DATA_W  last received payload; valid when rx_valid.
- rx_valid  output  1  one-cycle pulse, good frame received.
- rx_err  output  1  one-cycle pulse, framing (or parity) error.
- tx_data  input  DATA_W  reply payload.
- tx_valid  input  1  reply available; sampled at end of turnaround.
- tx_ack  output  1  one-cycle pulse, tx_data captured.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Frame: start bit 0, DATA_W data bits LSB first, stop bit 1; line idle level 1.
- Reset (rst=1 at a clk edge): state IDLE, data_en=0, data_out=1, rx_data=0, rx_valid=0, rx_err=0, tx_ack=0, busy=0, counters cleared, synchronizer flops set to 1. Reset mid-frame releases the line on the next edge.
- data_in passes through a 2-flop synchronizer (s_in). All sampling uses s_in.
- States: IDLE, RX_START, RX_DATA, RX_STOP, TURN, TX_START, TX_DATA, TX_STOP.
- IDLE: a falling edge on s_in (previous 1, current 0) moves to RX_START with the bit counter at 0.
- RX_START: at count BIT_CYCLES/2-1, sample s_in. If it is 0, go to RX_DATA with the counter cleared. If it is 1, treat it as a glitch and return to IDLE with no pulse.
- RX_DATA: sample each bit at count BIT_CYCLES-1, so every sample lands mid-bit. Shift the bit into the MSB of the shift register. After DATA_W samples, go to RX_STOP.
- RX_STOP: sample at count BIT_CYCLES-1.
  - If s_in=1: rx_data updates to the shift register and rx_valid pulses in the same cycle; go to TURN.
  - If s_in=0: rx_err pulses, rx_data is held, go to IDLE. No reply is sent.
- TURN: wait TURN_CYCLES cycles, then evaluate tx_valid in the last TURN cycle.
  - If tx_valid=1: latch tx_data, pulse tx_ack in that cycle, go to TX_START.
  - If tx_valid=0: return to IDLE.
- TX_START / TX_DATA / TX_STOP: data_en=1 throughout. Each bit holds BIT_CYCLES cycles. data_out is 0 for start, then the data bits LSB first, then 1 for stop.
- After the stop bit, data_en drops to 0 in the next cycle and the state returns to IDLE.
- While data_en=1, s_in is ignored, so the block does not detect its own echo.
- Reply frame length is (DATA_W+2)*BIT_CYCLES cycles, with data_en high for exactly that many cycles.
- The edge detector needs s_in=1 then 0. After an rx_err caused by a line stuck at 0, no new frame starts until the line returns high.
- rx_valid, rx_err and tx_ack are mutually exclusive; at most one pulses in any cycle.

Optional Feature:
- Macro: SW_RESPONDER_PARITY_EN.
- Defined:
  - An even-parity bit follows the data bits in both directions, giving a frame of DATA_W+3 bits.
  - A received parity mismatch with a good stop bit pulses rx_err. rx_valid does not pulse, rx_data is held, and the block returns to IDLE with no reply.
  - Transmit inserts the even-parity bit of tx_data.
- Undefined: no parity bit; frame as above.

Test Plan:
- Reset: assert rst for 3 cycles mid-reply (data_en=1) -> next edge data_en=0, data_out=1, busy=0, all pulses 0.
- Good receive: defaults, initiator sends 0xA5 with 16-cycle bits, tx_valid=0 -> rx_valid one pulse with rx_data=0xA5, no tx_ack, data_en never 1, busy low 4 cycles after rx_valid.
- Receive then reply: initiator sends 0x3C, tx_valid=1 with tx_data=0x96 -> tx_ack pulses 4 cycles after rx_valid. data_en is then high for exactly 160 cycles, and data_out carries 0, bits 0,1,1,0,1,0,0,1, then 1.
- Framing error: initiator sends 0x55 with stop bit 0 -> rx_err pulse, rx_data unchanged, no tx_ack. A new frame is accepted only after the line returns to 1.
- Glitch: drive line 0 for 3 cycles then 1 -> returns to IDLE, no rx_valid or rx_err. A following valid 0x01 frame is received correctly.
- With SW_RESPONDER_PARITY_EN: send 0x07 with parity 0 (wrong) -> rx_err, no reply. Send 0x07 with parity 1 -> rx_valid. With tx_data=0x03 the reply parity bit is 0.
